// File: rtl/fta_resp_tracker.sv
// Outstanding-transaction tracker: matches responses to issued requests by tid
// and synthesizes timeout error responses for requests that never get one.
package fta_bus_pkg;
    typedef logic [31:0] fta_address_t;

    typedef struct packed {
        logic [3:0] channel;
        logic [7:0] tranid;
    } fta_tranid_t;

    typedef enum logic [2:0] {
        OKAY    = 3'd0,
        DECERR  = 3'd1,
        PROTERR = 3'd2,
        ERR     = 3'd3,
        TIMEOUT = 3'd4
    } fta_err_t;

    typedef struct packed {
        logic [3:0]   cid;
        fta_tranid_t  tid;
        logic         stall;
        logic         next;
        logic         ack;
        logic         rty;
        fta_err_t     err;
        logic [3:0]   pri;
        fta_address_t adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;

    function automatic fta_cmd_response128_t resp_idle();
        fta_cmd_response128_t r;
        r     = '0;
        r.pri = 4'hF;
        return r;
    endfunction
endpackage

module fta_resp_tracker #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_v,
    input  fta_bus_pkg::fta_tranid_t         req_tid,
    input  fta_bus_pkg::fta_address_t        req_adr,
    output logic                             req_rdy,
    input  fta_bus_pkg::fta_cmd_response128_t resp_i,
    output fta_bus_pkg::fta_cmd_response128_t resp_o,
    output logic [$clog2(DEPTH):0]           cnt_o,
    output logic                             unexp_o,
    output logic                             ovf_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [DEPTH-1:0]          expired_q, expired_d;
    fta_bus_pkg::fta_tranid_t  tid_q   [DEPTH];
    fta_bus_pkg::fta_tranid_t  tid_d   [DEPTH];
    fta_bus_pkg::fta_address_t adr_q   [DEPTH];
    fta_bus_pkg::fta_address_t adr_d   [DEPTH];
    logic [TW-1:0]             timer_q [DEPTH];
    logic [TW-1:0]             timer_d [DEPTH];

    fta_bus_pkg::fta_cmd_response128_t resp_q, resp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          unexp_q, unexp_d;
    logic          ovf_q, ovf_d;

    logic          free_hit, match_hit, exp_hit;
    logic [IW-1:0] free_idx, match_idx, exp_idx;

    // Only registered occupancy gates allocation, so a slot freed this cycle waits a cycle.
    assign req_rdy = ~&valid_q;

    always_comb begin
        valid_d   = valid_q;
        expired_d = expired_q;
        tid_d     = tid_q;
        adr_d     = adr_q;
        timer_d   = timer_q;
        free_hit  = 1'b0;
        free_idx  = '0;
        match_hit = 1'b0;
        match_idx = '0;
        exp_hit   = 1'b0;
        exp_idx   = '0;
        cnt_d     = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !free_hit) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
            if (resp_i.ack && valid_q[i] && !expired_q[i] &&
                tid_q[i] == resp_i.tid && !match_hit) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
            if (expired_q[i] && !exp_hit) begin
                exp_hit = 1'b1;
                exp_idx = IW'(i);
            end
            if (valid_q[i] && !expired_q[i]) begin
                if (timer_q[i] == TMAX) begin
                    expired_d[i] = 1'b1;
                end else begin
                    timer_d[i] = timer_q[i] + 1'b1;
                end
            end
        end

        resp_d  = fta_bus_pkg::resp_idle();
        unexp_d = resp_i.ack && !match_hit;
        ovf_d   = req_v && !req_rdy;

        // A match on a slot reaching TIMEOUT this cycle also clears its fresh expired flag.
        if (match_hit) begin
            resp_d               = resp_i;
            resp_d.ack           = 1'b1;
            valid_d[match_idx]   = 1'b0;
            expired_d[match_idx] = 1'b0;
            timer_d[match_idx]   = '0;
        end else if (exp_hit) begin
            resp_d.ack         = 1'b1;
            resp_d.err         = fta_bus_pkg::TIMEOUT;
            resp_d.tid         = tid_q[exp_idx];
            resp_d.cid         = tid_q[exp_idx].channel;
            resp_d.adr         = adr_q[exp_idx];
            valid_d[exp_idx]   = 1'b0;
            expired_d[exp_idx] = 1'b0;
            timer_d[exp_idx]   = '0;
        end

        if (req_v && req_rdy) begin
            valid_d[free_idx]   = 1'b1;
            expired_d[free_idx] = 1'b0;
            tid_d[free_idx]     = req_tid;
            adr_d[free_idx]     = req_adr;
            timer_d[free_idx]   = '0;
        end

        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            expired_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tid_q[i]   <= '0;
                adr_q[i]   <= '0;
                timer_q[i] <= '0;
            end
            resp_q  <= fta_bus_pkg::resp_idle();
            cnt_q   <= '0;
            unexp_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            expired_q <= expired_d;
            tid_q     <= tid_d;
            adr_q     <= adr_d;
            timer_q   <= timer_d;
            resp_q    <= resp_d;
            cnt_q     <= cnt_d;
            unexp_q   <= unexp_d;
            ovf_q     <= ovf_d;
        end
    end

    assign resp_o  = resp_q;
    assign cnt_o   = cnt_q;
    assign unexp_o = unexp_q;
    assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_fta_resp_tracker.sv
// Scoreboard bench for fta_resp_tracker: expected responses queued with their due cycle.
module tb_fta_resp_tracker;
    import fta_bus_pkg::*;

    localparam int DEPTH = 8;
    localparam int TO    = 15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_v;
    fta_tranid_t          req_tid;
    fta_address_t         req_adr;
    logic                 req_rdy;
    fta_cmd_response128_t resp_i;
    fta_cmd_response128_t resp_o;
    logic [3:0]           cnt_o;
    logic                 unexp_o;
    logic                 ovf_o;

    fta_resp_tracker #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_v(req_v), .req_tid(req_tid), .req_adr(req_adr),
        .req_rdy(req_rdy), .resp_i(resp_i), .resp_o(resp_o), .cnt_o(cnt_o),
        .unexp_o(unexp_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        fta_cmd_response128_t r;
        int                   cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   base;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_o.ack) begin
            if (sb_q.size() == 0) begin
                check("spurious_resp", 256'(resp_o), 256'(0));
            end else begin
                mon_e = sb_q.pop_front();
                check("resp", 256'(resp_o), 256'(mon_e.r));
                check("resp_cycle", 256'(cyc), 256'(mon_e.cyc));
            end
        end
    end

    function automatic fta_tranid_t mk_tid(input logic [7:0] t);
        fta_tranid_t x;
        x.channel = t[3:0] ^ 4'h5;
        x.tranid  = t;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [7:0] t, input logic [31:0] a);
        req_v   = 1'b1;
        req_tid = mk_tid(t);
        req_adr = a;
        tick();
        req_v = 1'b0;
    endtask

    task automatic set_resp(input logic [7:0] t, input logic [127:0] d);
        resp_i     = '0;
        resp_i.ack = 1'b1;
        resp_i.tid = mk_tid(t);
        resp_i.cid = 4'h3;
        resp_i.adr = 32'hBEEF_0000 | 32'(t);
        resp_i.pri = 4'h2;
        resp_i.dat = d;
    endtask

    task automatic push_match_exp();
        exp_t e;
        e.r     = resp_i;
        e.r.ack = 1'b1;
        e.cyc   = cyc + 1;
        sb_q.push_back(e);
    endtask

    task automatic push_match(input logic [7:0] t, input logic [127:0] d);
        set_resp(t, d);
        push_match_exp();
        tick();
        resp_i = '0;
    endtask

    task automatic push_timeout(input logic [7:0] t, input logic [31:0] a, input int at);
        exp_t e;
        e.r     = resp_idle();
        e.r.ack = 1'b1;
        e.r.err = TIMEOUT;
        e.r.tid = mk_tid(t);
        e.r.cid = mk_tid(t).channel;
        e.r.adr = a;
        e.cyc   = at;
        sb_q.push_back(e);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        rst = 1'b1; req_v = 1'b0; req_tid = '0; req_adr = '0; resp_i = '0;
        repeat (3) tick();
        check("rst_cnt", 256'(cnt_o), 256'(0));
        check("rst_resp", 256'(resp_o), 256'(resp_idle()));
        check("rst_unexp", 256'(unexp_o), 256'(0));
        check("rst_ovf", 256'(ovf_o), 256'(0));
        check("rst_rdy", 256'(req_rdy), 256'(1));
        rst = 1'b0;
        tick();

        // matched response three cycles after issue
        do_req(8'd5, 32'h40);
        check("s1_cnt1", 256'(cnt_o), 256'(1));
        tick(); tick();
        push_match(8'd5, 128'hA5);
        check("s1_cnt0", 256'(cnt_o), 256'(0));

        // simultaneous allocate and free keeps the count
        do_req(8'h30, 32'h300);
        req_v = 1'b1; req_tid = mk_tid(8'h31); req_adr = 32'h310;
        set_resp(8'h30, 128'h30);
        push_match_exp();
        tick();
        req_v = 1'b0; resp_i = '0;
        check("s_af_cnt", 256'(cnt_o), 256'(1));
        push_match(8'h31, 128'h31);
        check("s_af_cnt0", 256'(cnt_o), 256'(0));

        // plain timeout, 17 cycles after allocation
        base = cyc;
        push_timeout(8'd3, 32'h1000, base + 18);
        do_req(8'd3, 32'h1000);
        run_to(base + 17);
        check("s2_cnt_pend", 256'(cnt_o), 256'(1));
        tick();
        check("s2_cnt0", 256'(cnt_o), 256'(0));
        tick();

        // matched response beats a pending timeout, which follows next cycle
        base = cyc;
        do_req(8'h13, 32'h2000);
        do_req(8'h16, 32'h3000);
        run_to(base + 17);
        push_match(8'h16, 128'h66);
        push_timeout(8'h13, 32'h2000, base + 19);
        run_to(base + 20);
        check("s5_cnt0", 256'(cnt_o), 256'(0));

        // duplicate tids free in ascending slot order
        base = cyc;
        do_req(8'd7, 32'h70);
        do_req(8'd7, 32'h71);
        push_match(8'd7, 128'h77);
        push_timeout(8'd7, 32'h71, base + 19);
        run_to(base + 20);
        check("dup_cnt0", 256'(cnt_o), 256'(0));

        // fill all slots, then overflow
        for (int i = 0; i < DEPTH; i++) do_req(8'h40 + 8'(i), 32'h4000 + 32'(i));
        check("full_rdy", 256'(req_rdy), 256'(0));
        check("full_cnt", 256'(cnt_o), 256'(8));
        do_req(8'h99, 32'h9999);
        check("ovf_pulse", 256'(ovf_o), 256'(1));
        check("ovf_cnt", 256'(cnt_o), 256'(8));
        tick();
        check("ovf_clear", 256'(ovf_o), 256'(0));
        for (int i = 0; i < DEPTH; i++) push_match(8'h40 + 8'(i), 128'(i) + 128'h100);
        check("drain_cnt", 256'(cnt_o), 256'(0));

        // unexpected response
        set_resp(8'd9, 128'h9);
        tick();
        resp_i = '0;
        check("unexp_pulse", 256'(unexp_o), 256'(1));
        check("unexp_noack", 256'(resp_o.ack), 256'(0));
        tick();
        check("unexp_clear", 256'(unexp_o), 256'(0));

        // reset with outstanding slots
        for (int i = 0; i < 4; i++) do_req(8'h20 + 8'(i), 32'h2200 + 32'(i));
        check("pre_rst_cnt", 256'(cnt_o), 256'(4));
        rst = 1'b1;
        tick();
        check("mid_rst_cnt", 256'(cnt_o), 256'(0));
        check("mid_rst_resp", 256'(resp_o), 256'(resp_idle()));
        rst = 1'b0;
        repeat (25) tick();
        set_resp(8'h20, 128'h20);
        tick();
        resp_i = '0;
        check("post_rst_unexp", 256'(unexp_o), 256'(1));
        check("post_rst_cnt", 256'(cnt_o), 256'(0));

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
        check("sb_empty", 256'(sb_q.size()), 256'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fta_resp_tracker.md
FTA_RESP_TRACKER -- requirements
Module: fta_resp_tracker

Interface
REQ-001 Parameter DEPTH, default 8, is the number of outstanding-transaction slots (power of 2, 2..32).
REQ-002 Parameter TIMEOUT, default 1023, is the number of cycles a slot may wait before a timeout error response is synthesized (1..65535).
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req_v  input  1  request issued this cycle; allocate a slot.
REQ-006 Port req_tid  input  fta_tranid_t  transaction id of the issued request.
REQ-007 Port req_adr  input  fta_address_t  address of the issued request.
REQ-008 Port req_rdy  output  1  combinational; high when at least one slot is free.
REQ-009 Port resp_i  input  fta_cmd_response128_t  serialized response stream from the response buffer; valid when resp_i.ack is high.
REQ-010 Port resp_o  output  fta_cmd_response128_t  registered response stream: matched responses and synthesized timeouts.
REQ-011 Port cnt_o  output  $clog2(DEPTH)+1  registered count of occupied slots.
REQ-012 Port unexp_o  output  1  registered one-cycle pulse; response arrived with no matching slot.
REQ-013 Port ovf_o  output  1  registered one-cycle pulse; req_v arrived while no slot was free.

Function
REQ-014 Each slot SHALL hold valid, tid, adr, a timer of $clog2(TIMEOUT+1) bits, and an expired flag.
REQ-015 On req_v with req_rdy high, the lowest-index free slot SHALL be loaded: valid=1, tid=req_tid, adr=req_adr, timer=0, expired=0.
REQ-016 req_rdy SHALL be computed from the registered slot state only; a slot freed in the same cycle SHALL NOT be reusable until the next cycle.
REQ-017 On req_v with req_rdy low, no slot SHALL change, and ovf_o SHALL pulse high the next cycle.
REQ-018 On resp_i.ack high, the lowest-index valid, unexpired slot whose tid equals resp_i.tid SHALL be freed.
REQ-019 A matched response SHALL appear on resp_o exactly one cycle later, with all fields copied from resp_i and ack=1.
REQ-020 On resp_i.ack with no matching slot, resp_i SHALL be discarded, and unexp_o SHALL pulse high the next cycle.
REQ-021 The timer of each valid, unexpired slot SHALL increment by 1 per cycle and saturate at TIMEOUT.
REQ-022 When a slot's timer equals TIMEOUT, its expired flag SHALL set; a response matching that slot in the same cycle takes precedence, frees the slot, and no timeout is emitted.
REQ-023 When no matched response is being emitted, the lowest-index expired slot SHALL drive a timeout response on resp_o next cycle and then be freed.
REQ-024 Timeout response fields: ack=1, err=TIMEOUT code from fta_bus_pkg, rty=0, dat=0, tid=slot tid, adr=slot adr, cid=slot tid channel field, stall=0, next=0, pri=4'hF.
REQ-025 When no response is emitted, resp_o SHALL be all-zero except pri=4'hF.
REQ-026 resp_o SHALL carry at most one response per cycle; matched responses always win over pending timeouts, which wait without loss.
REQ-027 Simultaneous allocate and free of different slots SHALL be allowed in one cycle; cnt_o SHALL reflect the net change (+1, -1, or 0).
REQ-028 Expired slots remain occupied, and count in cnt_o, until their timeout response is emitted.
REQ-029 Duplicate tids SHALL be allowed in separate slots; responses free them in ascending slot-index order.

Reset
REQ-030 While rst is high, all slot valid and expired flags SHALL be 0 and all timers SHALL be 0.
REQ-031 While rst is high, resp_o SHALL be zero except pri=4'hF, cnt_o SHALL be 0, and unexp_o and ovf_o SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all outstanding slots and pending timeouts, with no response emitted afterward for them.

Verification
REQ-033 Bench SHALL cover these directed scenarios:
- req_v tid=5; 3 cycles later resp_i.ack tid=5 dat=0xA5 -> resp_o.ack=1, dat=0xA5 one cycle later; cnt_o goes 1 then 0.
- TIMEOUT=15: req tid=3 adr=0x1000 with no response -> timeout resp_o (err=TIMEOUT, tid=3, adr=0x1000) 17 cycles after allocation; cnt_o back to 0.
- DEPTH=8: allocate 8 -> req_rdy=0; 9th req_v -> ovf_o pulse, cnt_o stays 8.
- resp_i.ack tid=9 with no slot holding 9 -> unexp_o pulse, resp_o.ack stays 0.
- Timeout pending in same cycle as a matched response -> matched response out first, timeout out on the following cycle.
- rst asserted with 4 slots outstanding -> cnt_o=0; later resp_i tid matching a pre-reset slot -> unexp_o pulse.
